ram_rom_alu: RTL and testbench
==============================

RAM_ROM_ALU -- requirements
Module: ram_rom_alu

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, ALU operand/result width.
REQ-002 The module SHALL have parameter ADDR_W, default 5, program address width (32 words).
REQ-003 The module SHALL have parameter CODE_W, default 23, code word width.
REQ-004 The module SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port ad_in, input, ADDR_W, next program address from the controller.
REQ-008 Port ad_out, output, ADDR_W, registered program address.
REQ-009 Port code, output, CODE_W, ROM word at ad_out.
REQ-010 Port p, input, DATA_W, ALU operand A (accumulator side).
REQ-011 Port q, input, DATA_W, ALU operand B (bus side).
REQ-012 Port math_en, input, 7, one-hot operation select.
REQ-013 Port g, output, DATA_W, ALU result.

Function
REQ-014 Address register: ad_out SHALL load ad_in on every rising clk edge when rst=0.
REQ-015 ROM SHALL be combinational read-only: code = ROM_IMAGE[ad_out], valid in the same cycle ad_out changes (one-cycle latency from ad_in).
REQ-016 Code word fields: func = code[22:19], rx = code[18:16], imm = code[15:0].
REQ-017 ROM_IMAGE SHALL hold: addr0 = 23'h000005 (load R0,5); addr1 = 23'h010003 (load R1,3); addr2 = 23'h080001 (add R0,R1); addr3 = 23'h780000 (halt); all other addresses = 0.
REQ-018 ALU SHALL be purely combinational, unsigned; math_en bit map: [6] add, [5] sub, [4] xor, [3] and, [2] or, [1] div, [0] mod.
REQ-019 add: g = (p+q) mod 2^16; sub: g = (p-q) mod 2^16 (wraps, no flags).
REQ-020 xor/and/or: bitwise on full DATA_W.
REQ-021 div: g = floor(p/q); q=0 SHALL give g = 16'hFFFF.
REQ-022 mod: g = p mod q; q=0 SHALL give g = p.
REQ-023 math_en = 0 SHALL give g = 0.
REQ-024 Multiple bits set: highest set bit SHALL win (add > sub > xor > and > or > div > mod).
REQ-025 Address wrap: ad_in is taken verbatim; 31 -> 0 sequencing is the controller's responsibility, ROM index wraps at 2^ADDR_W.

Reset
REQ-026 rst=1 at a rising edge SHALL set ad_out = 0, so code = 23'h000005; rst dominates ad_in.
REQ-027 Reset mid-program SHALL take effect at the next edge only; no asynchronous effect.
REQ-028 ALU and ROM SHALL have no state and SHALL be unaffected by rst.

Structure
REQ-029 A shared package SHALL hold DATA_W/ADDR_W/CODE_W defaults, the math_en bit-index constants, the func codes (LOAD=0, ADD=1, HALT=15), and ROM_IMAGE.
REQ-030 One sub-module, alu16, SHALL implement REQ-018..REQ-024; address register and ROM SHALL be inline in ram_rom_alu.

Verification
REQ-031 rst=1 one edge, ad_in=7 -> ad_out=0, code=23'h000005.
REQ-032 rst=0, ad_in=0,1,2,3 on successive edges -> code 23'h000005, 23'h010003, 23'h080001, 23'h780000 one cycle after each.
REQ-033 p=5, q=3: math_en=7'b1000000 -> g=8; 7'b0100000 -> g=2; 7'b0010000 -> g=6; 7'b0001000 -> g=1; 7'b0000100 -> g=7.
REQ-034 p=3, q=5, sub -> g=16'hFFFE; p=16'hFFFF, q=1, add -> g=0.
REQ-035 p=17, q=5: div -> 3, mod -> 2; q=0: div -> 16'hFFFF, mod -> 17; math_en=0 -> 0; math_en=7'b1100000 -> add result 22.
REQ-036 ad_in=31 then 0 -> ad_out 31 (code 0) then 0 (code 23'h000005); assert rst during sequence -> ad_out=0 next edge.

Source files
------------

// File: rtl/ram_rom_alu_pkg.sv
// Shared constants for the program-ROM / ALU slice: default widths, ALU select
// bit positions, instruction encodings and the fixed program image.
package ram_rom_alu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CODE_W = 23;

    localparam int MATH_W   = 7;
    localparam int MATH_ADD = 6;
    localparam int MATH_SUB = 5;
    localparam int MATH_XOR = 4;
    localparam int MATH_AND = 3;
    localparam int MATH_OR  = 2;
    localparam int MATH_DIV = 1;
    localparam int MATH_MOD = 0;

    typedef enum logic [3:0] {
        FUNC_LOAD = 4'd0,
        FUNC_ADD  = 4'd1,
        FUNC_HALT = 4'd15
    } func_e;

    typedef struct packed {
        func_e       func;
        logic [2:0]  rx;
        logic [15:0] imm;
    } code_word_t;

    localparam int ROM_DEPTH = 32;

    function automatic logic [DEF_CODE_W-1:0] make_code(
        input func_e       func,
        input logic [2:0]  rx,
        input logic [15:0] imm
    );
        code_word_t w;
        w.func = func;
        w.rx   = rx;
        w.imm  = imm;
        return w;
    endfunction

    // Words beyond the short demo program stay zero.
    function automatic logic [ROM_DEPTH-1:0][DEF_CODE_W-1:0] build_rom_image();
        logic [ROM_DEPTH-1:0][DEF_CODE_W-1:0] r;
        r    = '0;
        r[0] = make_code(FUNC_LOAD, 3'd0, 16'd5);
        r[1] = make_code(FUNC_LOAD, 3'd1, 16'd3);
        r[2] = make_code(FUNC_ADD,  3'd0, 16'd1);
        r[3] = make_code(FUNC_HALT, 3'd0, 16'd0);
        return r;
    endfunction

    localparam logic [ROM_DEPTH-1:0][DEF_CODE_W-1:0] ROM_IMAGE = build_rom_image();

endpackage

// File: rtl/ram_rom_alu_alu16.sv
// Stateless unsigned ALU with a one-hot operation select; when several select
// bits are set the highest-numbered one wins.
module alu16
    import ram_rom_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] p,
    input  logic [DATA_W-1:0] q,
    input  logic [MATH_W-1:0] math_en,
    output logic [DATA_W-1:0] g
);

    logic [DATA_W-1:0] g_next;
    logic              q_zero;

    assign q_zero = (q == '0);

    always_comb begin
        g_next = '0;
        if (math_en[MATH_ADD]) begin
            g_next = p + q;
        end else if (math_en[MATH_SUB]) begin
            g_next = p - q;
        end else if (math_en[MATH_XOR]) begin
            g_next = p ^ q;
        end else if (math_en[MATH_AND]) begin
            g_next = p & q;
        end else if (math_en[MATH_OR]) begin
            g_next = p | q;
        end else if (math_en[MATH_DIV]) begin
            // Divide by zero saturates to all ones rather than being undefined.
            g_next = q_zero ? '1 : p / q;
        end else if (math_en[MATH_MOD]) begin
            g_next = q_zero ? p : p % q;
        end
    end

    assign g = g_next;

endmodule

// File: rtl/ram_rom_alu.sv
// Program address register feeding a combinational program ROM, alongside a
// stateless ALU. Only the address register is clocked and reset.
module ram_rom_alu
    import ram_rom_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CODE_W = DEF_CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ad_in,
    output logic [ADDR_W-1:0] ad_out,
    output logic [CODE_W-1:0] code,
    input  logic [DATA_W-1:0] p,
    input  logic [DATA_W-1:0] q,
    input  logic [6:0]        math_en,
    output logic [DATA_W-1:0] g
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [ADDR_W-1:0] ad_reg;
    logic [CODE_W-1:0] rom_words [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            ad_reg <= '0;
        end else begin
            ad_reg <= ad_in;
        end
    end

    assign ad_out = ad_reg;

    // Address space larger than the program image reads back as zero.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_rom
        if (gi < ROM_DEPTH) begin : g_img
            assign rom_words[gi] = CODE_W'(ROM_IMAGE[gi]);
        end else begin : g_zero
            assign rom_words[gi] = '0;
        end
    end

    assign code = rom_words[ad_reg];

    alu16 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .p       (p),
        .q       (q),
        .math_en (math_en),
        .g       (g)
    );

endmodule

// File: tb/tb_ram_rom_alu.sv
// Directed vectors for the address register, program ROM and ALU, checked by a
// queue-based scoreboard that compares on the falling clock edge.
module tb_ram_rom_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ad_in;
    logic [4:0]  ad_out;
    logic [22:0] code;
    logic [15:0] p;
    logic [15:0] q;
    logic [6:0]  math_en;
    logic [15:0] g;

    ram_rom_alu dut (
        .clk     (clk),
        .rst     (rst),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .code    (code),
        .p       (p),
        .q       (q),
        .math_en (math_en),
        .g       (g)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sel;   // 0 = ad_out, 1 = code, 2 = g
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb [$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    sb_entry_t   cur;
    logic [31:0] act;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compare every entry whose due cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            cur = sb.pop_front();
            case (cur.sel)
                0:       act = 32'(ad_out);
                1:       act = 32'(code);
                default: act = 32'(g);
            endcase
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end else begin
                $display("ok   %s: %h", cur.name, act);
            end
        end
    end

    task automatic expect_val(input int due, input int sel, input string name,
                              input logic [31:0] exp);
        sb_entry_t e;
        e.due  = due;
        e.sel  = sel;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_vec(input logic rv, input logic [4:0] ad, input string name,
                            input logic [4:0] exp_ad, input logic [22:0] exp_code);
        rst   = rv;
        ad_in = ad;
        expect_val(cycle + 1, 0, {name, ".ad_out"}, 32'(exp_ad));
        expect_val(cycle + 1, 1, {name, ".code"}, 32'(exp_code));
        step();
    endtask

    task automatic alu_vec(input logic [15:0] pv, input logic [15:0] qv,
                           input logic [6:0] m, input string name,
                           input logic [15:0] exp_g);
        p       = pv;
        q       = qv;
        math_en = m;
        expect_val(cycle, 2, name, 32'(exp_g));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ad_in = '0; p = '0; q = '0; math_en = '0;
        step();

        addr_vec(1'b1, 5'd7, "reset_ad7", 5'd0, 23'h000005);
        addr_vec(1'b0, 5'd0, "prog0", 5'd0, 23'h000005);
        addr_vec(1'b0, 5'd1, "prog1", 5'd1, 23'h010003);
        addr_vec(1'b0, 5'd2, "prog2", 5'd2, 23'h080001);
        addr_vec(1'b0, 5'd3, "prog3", 5'd3, 23'h780000);
        addr_vec(1'b0, 5'd31, "wrap31", 5'd31, 23'h000000);
        addr_vec(1'b0, 5'd0, "wrap0", 5'd0, 23'h000005);
        addr_vec(1'b0, 5'd2, "pre_rst", 5'd2, 23'h080001);
        // Reset raised mid-program must not disturb ad_out before the edge.
        expect_val(cycle, 0, "rst_no_async.ad_out", 32'd2);
        addr_vec(1'b1, 5'd3, "mid_rst", 5'd0, 23'h000005);
        addr_vec(1'b0, 5'd20, "empty20", 5'd20, 23'h000000);

        alu_vec(16'd5, 16'd3, 7'b1000000, "add_5_3", 16'd8);
        alu_vec(16'd5, 16'd3, 7'b0100000, "sub_5_3", 16'd2);
        alu_vec(16'd5, 16'd3, 7'b0010000, "xor_5_3", 16'd6);
        alu_vec(16'd5, 16'd3, 7'b0001000, "and_5_3", 16'd1);
        alu_vec(16'd5, 16'd3, 7'b0000100, "or_5_3", 16'd7);
        alu_vec(16'd3, 16'd5, 7'b0100000, "sub_wrap", 16'hFFFE);
        alu_vec(16'hFFFF, 16'd1, 7'b1000000, "add_wrap", 16'h0000);
        alu_vec(16'd17, 16'd5, 7'b0000010, "div_17_5", 16'd3);
        alu_vec(16'd17, 16'd5, 7'b0000001, "mod_17_5", 16'd2);
        alu_vec(16'd17, 16'd0, 7'b0000010, "div_by0", 16'hFFFF);
        alu_vec(16'd17, 16'd0, 7'b0000001, "mod_by0", 16'd17);
        alu_vec(16'd17, 16'd5, 7'b0000000, "none", 16'd0);
        alu_vec(16'd17, 16'd5, 7'b1100000, "prio_add_sub", 16'd22);
        alu_vec(16'd17, 16'd5, 7'b0011000, "prio_xor_and", 16'd20);
        alu_vec(16'd17, 16'd5, 7'b0000011, "prio_div_mod", 16'd3);
        alu_vec(16'hA5A5, 16'h0FF0, 7'b0010000, "xor_wide", 16'hAA55);
        // ALU must ignore reset.
        rst = 1'b1;
        alu_vec(16'd100, 16'd7, 7'b0000001, "mod_in_rst", 16'd2);
        rst = 1'b0;

        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
